// File: rtl/cmd_tx.sv
// cmd_tx: transmit side of the command link. A request is accepted in IDLE.
// It is turned into a 32-bit command word, and the word is sent as four bytes,
// most significant byte first, over a valid/ready byte stream. A request
// with an unknown id is accepted and dropped. The drop is flagged on
// err_bad_id for one cycle.
//
// Parameters:
//   BYTE_GAP     idle cycles inserted after each byte except the last (0..15)
// Ports:
//   clk          clock; all logic uses the rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    request valid
//   req_ready    high while the block can accept a request (IDLE only)
//   req_id       command id (BANK = 4'h0, OUT = 4'h1)
//   req_bank_en  bank-enable field (BANK only)
//   req_bank_val bank value field (BANK only)
//   req_out_cmd  output command field (OUT only)
//   tx_valid     tx_data carries a byte
//   tx_ready     downstream accepts the byte
//   tx_data      serialized byte; 8'h00 whenever tx_valid is low
//   busy         high in any state other than IDLE
//   err_bad_id   one-cycle pulse after a request with an unknown id is accepted
module cmd_tx #(
    parameter int BYTE_GAP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_id,
    input  logic [3:0] req_bank_en,
    input  logic [7:0] req_bank_val,
    input  logic [4:0] req_out_cmd,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       err_bad_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] ID_BANK  = 4'b0000;
    localparam logic [3:0] ID_OUT   = 4'b0001;
    localparam bit         HAS_GAP  = (BYTE_GAP > 0);
    localparam int         GAP_M1   = HAS_GAP ? (BYTE_GAP - 1) : 0;
    // The gap counter counts down to zero. Loading BYTE_GAP-1 makes GAP last
    // exactly BYTE_GAP cycles.
    localparam logic [3:0] GAP_LOAD = GAP_M1[3:0];

    state_t      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        err_q, err_d;
    logic        accept;
    logic [7:0]  byte_sel;

    // rst_n gates req_ready so that ready drops the moment reset is applied.
    // Ready comes back in the first cycle after release.
    assign req_ready  = (state_q == IDLE) && rst_n;
    assign accept     = req_valid && req_ready;
    assign busy       = (state_q != IDLE);
    assign tx_valid   = (state_q == SEND);
    assign err_bad_id = err_q;

    always_comb begin
        byte_sel = 8'h00;
        case (byte_idx_q)
            2'd0:    byte_sel = word_q[31:24];
            2'd1:    byte_sel = word_q[23:16];
            2'd2:    byte_sel = word_q[15:8];
            default: byte_sel = word_q[7:0];
        endcase
    end

    assign tx_data = tx_valid ? byte_sel : 8'h00;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    byte_idx_d = 2'd0;
                    if (req_id == ID_BANK) begin
                        word_d  = {ID_BANK, 12'h000, req_bank_val, 4'h0, req_bank_en};
                        state_d = SEND;
                    end else if (req_id == ID_OUT) begin
                        word_d  = {ID_OUT, 23'h000000, req_out_cmd};
                        state_d = SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (byte_idx_q == 2'd3) begin
                        // The last byte never gets a gap after it. The block goes
                        // straight back to IDLE.
                        byte_idx_d = 2'd0;
                        state_d    = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (HAS_GAP) begin
                            gap_cnt_d = GAP_LOAD;
                            state_d   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= 32'h0;
            byte_idx_q <= 2'd0;
            gap_cnt_q  <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_cmd_tx.sv
// Testbench for cmd_tx. It drives directed vectors with hand-computed
// expected bytes into two instances:
//   dut      uses BYTE_GAP = 0
//   dut_gap  uses BYTE_GAP = 2
module tb_cmd_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       g_req_valid;
    logic [3:0] req_id;
    logic [3:0] req_bank_en;
    logic [7:0] req_bank_val;
    logic [4:0] req_out_cmd;
    logic       tx_ready;

    logic       req_ready, tx_valid, busy, err_bad_id;
    logic [7:0] tx_data;
    logic       g_req_ready, g_tx_valid, g_busy, g_err_bad_id;
    logic [7:0] g_tx_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmd_tx #(.BYTE_GAP(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_bank_en(req_bank_en),
        .req_bank_val(req_bank_val), .req_out_cmd(req_out_cmd),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .busy(busy), .err_bad_id(err_bad_id)
    );

    cmd_tx #(.BYTE_GAP(2)) dut_gap (
        .clk(clk), .rst_n(rst_n),
        .req_valid(g_req_valid), .req_ready(g_req_ready),
        .req_id(req_id), .req_bank_en(req_bank_en),
        .req_bank_val(req_bank_val), .req_out_cmd(req_out_cmd),
        .tx_valid(g_tx_valid), .tx_ready(tx_ready), .tx_data(g_tx_data),
        .busy(g_busy), .err_bad_id(g_err_bad_id)
    );

    // Every comparison in the bench goes through this task
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Move to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle. On return we sit in the cycle
    // right after the request was accepted.
    task automatic applyStimulus(input logic [3:0] id, input logic [3:0] en,
                                 input logic [7:0] val, input logic [4:0] cmd,
                                 input bit use_gap);
        step();
        req_id       = id;
        req_bank_en  = en;
        req_bank_val = val;
        req_out_cmd  = cmd;
        if (use_gap) g_req_valid = 1'b1;
        else         req_valid   = 1'b1;
        #1;
        checkOutput("accept_ready", use_gap ? g_req_ready : req_ready, 1'b1);
        step();
        req_valid   = 1'b0;
        g_req_valid = 1'b0;
    endtask

    // Expect four back-to-back bytes from dut with tx_ready high. After the
    // last byte the block must be idle again.
    task automatic expectBytes(input string tag, input logic [31:0] word);
        for (int i = 0; i < 4; i++) begin
            checkOutput({tag, "_valid"}, tx_valid, 1'b1);
            checkOutput({tag, "_data"}, tx_data, word[31 - 8 * i -: 8]);
            checkOutput({tag, "_ready_low"}, req_ready, 1'b0);
            step();
        end
        checkOutput({tag, "_end_valid"}, tx_valid, 1'b0);
        checkOutput({tag, "_end_data"}, tx_data, 8'h00);
        checkOutput({tag, "_end_ready"}, req_ready, 1'b1);
        checkOutput({tag, "_end_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        g_req_valid  = 1'b0;
        req_id       = 4'h0;
        req_bank_en  = 4'h0;
        req_bank_val = 8'h00;
        req_out_cmd  = 5'h00;
        tx_ready     = 1'b1;

        // Outputs while reset is held
        #2;
        checkOutput("rst_ready", req_ready, 1'b0);
        checkOutput("rst_valid", tx_valid, 1'b0);
        checkOutput("rst_data", tx_data, 8'h00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_err", err_bad_id, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", req_ready, 1'b1);

        // BANK frame
        $display("[TB] BANK frame");
        applyStimulus(4'h0, 4'hA, 8'h5C, 5'h1F, 1'b0);
        checkOutput("bank_busy", busy, 1'b1);
        expectBytes("bank", 32'h00005C0A);

        // OUT frame with nonzero bank inputs, which must be ignored
        $display("[TB] OUT frame");
        applyStimulus(4'h1, 4'hF, 8'hFF, 5'h13, 1'b0);
        expectBytes("out", 32'h10000013);

        // Stall on the second byte for 3 cycles
        $display("[TB] stall");
        applyStimulus(4'h0, 4'h3, 8'hA7, 5'h00, 1'b0);
        checkOutput("stall_b0", tx_data, 8'h00);
        step();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_valid", tx_valid, 1'b1);
            checkOutput("stall_data", tx_data, 8'h00);
            checkOutput("stall_ready", req_ready, 1'b0);
            step();
        end
        tx_ready = 1'b1;
        checkOutput("stall_b1", tx_data, 8'h00);
        step();
        checkOutput("stall_b2", tx_data, 8'hA7);
        step();
        checkOutput("stall_b3", tx_data, 8'h03);
        checkOutput("stall_b3_valid", tx_valid, 1'b1);
        step();
        checkOutput("stall_end_valid", tx_valid, 1'b0);
        checkOutput("stall_end_ready", req_ready, 1'b1);

        // An unknown id is accepted and flagged, and no bytes are sent
        $display("[TB] bad id");
        applyStimulus(4'h7, 4'h1, 8'h22, 5'h05, 1'b0);
        checkOutput("bad_err", err_bad_id, 1'b1);
        checkOutput("bad_valid", tx_valid, 1'b0);
        checkOutput("bad_ready", req_ready, 1'b1);
        checkOutput("bad_busy", busy, 1'b0);
        step();
        checkOutput("bad_err_clear", err_bad_id, 1'b0);
        checkOutput("bad_valid2", tx_valid, 1'b0);

        // Reset in the middle of a frame
        $display("[TB] reset abort");
        applyStimulus(4'h0, 4'h5, 8'h96, 5'h00, 1'b0);
        checkOutput("abort_b0", tx_data, 8'h00);
        step();
        checkOutput("abort_b1", tx_data, 8'h00);
        step();
        checkOutput("abort_b2", tx_data, 8'h96);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", tx_valid, 1'b0);
        checkOutput("abort_data", tx_data, 8'h00);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_ready", req_ready, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("abort_quiet", tx_valid, 1'b0);
            step();
        end
        applyStimulus(4'h1, 4'h0, 8'h00, 5'h1F, 1'b0);
        expectBytes("after_abort", 32'h1000001F);

        // BYTE_GAP = 2: each byte is followed by two empty cycles, except the last
        $display("[TB] gap frame");
        applyStimulus(4'h1, 4'h0, 8'h00, 5'h0B, 1'b1);
        for (int c = 0; c < 10; c++) begin
            logic [31:0] gw;
            logic        ev;
            logic [7:0]  ed;
            gw = 32'h1000000B;
            ev = (c % 3 == 0);
            ed = ev ? gw[31 - 8 * (c / 3) -: 8] : 8'h00;
            checkOutput("gap_valid", g_tx_valid, ev);
            checkOutput("gap_data", g_tx_data, ed);
            checkOutput("gap_busy", g_busy, 1'b1);
            step();
        end
        checkOutput("gap_end_valid", g_tx_valid, 1'b0);
        checkOutput("gap_end_ready", g_req_ready, 1'b1);
        checkOutput("gap_end_busy", g_busy, 1'b0);
        checkOutput("gap_err", g_err_bad_id, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_tx.md
CMD_TX -- requirements
Module: cmd_tx

Interface
REQ-001 SHALL have parameter BYTE_GAP, default 0: idle cycles inserted after each accepted byte (0..15).
REQ-002 SHALL have port clk  input  1  the single clock; all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  command request valid.
REQ-005 SHALL have port req_ready  output  1  block can accept a request.
REQ-006 SHALL have port req_id  input  4  command id (cmd_id_t: BANK=4'b0000, OUT=4'b0001).
REQ-007 SHALL have port req_bank_en  input  4  bank-enable field (BANK only).
REQ-008 SHALL have port req_bank_val  input  8  bank value field (BANK only).
REQ-009 SHALL have port req_out_cmd  input  5  output command field (OUT only).
REQ-010 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-011 SHALL have port tx_ready  input  1  downstream accepts byte.
REQ-012 SHALL have port tx_data  output  8  serialized command byte.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port err_bad_id  output  1  one-cycle pulse on rejected id.

Function
REQ-015 SHALL be the transmit-side counterpart of the command parser: build a 32-bit command word per the command ICD and emit it as 4 bytes.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on a clock edge with req_valid && req_ready, and all req_* fields are captured then.
REQ-017 SHALL build a BANK word as: [31:28]=4'b0000, [27:16]=0, [15:8]=req_bank_val, [7:4]=0, [3:0]=req_bank_en.
REQ-018 SHALL build an OUT word as: [31:28]=4'b0001, [27:5]=0, [4:0]=req_out_cmd.
REQ-019 SHALL force all reserved bits to 0 and ignore inputs unused by the selected id.
REQ-020 SHALL, for any other req_id, complete the handshake, emit no bytes, pulse err_bad_id high for exactly the cycle after acceptance, and remain in IDLE.
REQ-021 SHALL implement FSM states IDLE, SEND, GAP: IDLE->SEND on valid-id acceptance; SEND->GAP on byte handshake when BYTE_GAP>0 and bytes remain; SEND->SEND (next byte) when BYTE_GAP=0 and bytes remain; GAP->SEND after BYTE_GAP cycles; SEND->IDLE on 4th byte handshake.
REQ-022 SHALL assert tx_valid in the cycle after acceptance (1-cycle latency), MSB byte first: [31:24], [23:16], [15:8], [7:0].
REQ-023 SHALL hold tx_valid and tx_data stable while tx_valid && !tx_ready; a byte advances only on tx_valid && tx_ready.
REQ-024 SHALL drive tx_valid low in IDLE and GAP; tx_data SHALL be 8'h00 when tx_valid is low.
REQ-025 SHALL, after the 4th byte handshake, present req_ready=1 in the next cycle (no gap appended after the last byte).
REQ-026 SHALL sustain one byte per cycle with BYTE_GAP=0 and tx_ready held high (4-cycle frame, back-to-back frames separated by one IDLE cycle).
REQ-027 SHALL use a 2-bit byte index and a 4-bit gap counter; no wrap beyond byte 3.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force state IDLE, req_ready=0, tx_valid=0, tx_data=8'h00, busy=0, err_bad_id=0, counters=0.
REQ-029 SHALL assert req_ready in the first cycle after rst_n deasserts.
REQ-030 SHALL abort any frame in progress on reset; no remaining bytes are emitted after release.

Verification
REQ-031 BANK, en=4'hA, val=8'h5C, tx_ready=1 -> bytes 00,00,5C,0A on 4 consecutive cycles starting 1 cycle after accept.
REQ-032 OUT, out_cmd=5'h13, with bank inputs nonzero -> bytes 10,00,00,13; bank inputs have no effect.
REQ-033 BANK frame, tx_ready low 3 cycles on byte 2 -> tx_data holds 00 with tx_valid high for 3 cycles, then sequence continues unchanged; req_ready stays 0.
REQ-034 req_id=4'h7 -> handshake completes, err_bad_id high 1 cycle, tx_valid never asserts, req_ready high next cycle.
REQ-035 rst_n pulsed low after byte 2 accepted -> all outputs zero immediately, no further bytes; next request sends a full 4-byte frame.
REQ-036 BYTE_GAP=2, tx_ready=1 -> each byte followed by 2 cycles tx_valid=0, except none after the 4th byte; frame spans 10 cycles.
